// File: rtl/vdp_video_pkg.sv
// rtl/vdp_video_pkg.sv - video mode encodings, timing parameter table and controller state type
package vdp_video_pkg;

    localparam logic [1:0] MODE_800x600  = 2'd0;
    localparam logic [1:0] MODE_1024x768 = 2'd1;
    localparam logic [1:0] MODE_1280x720 = 2'd2;
    localparam logic [1:0] MODE_INVALID  = 2'd3;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_bporch;
        logic [11:0] h_res;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_bporch;
        logic [11:0] v_res;
        logic        hs_pol;
        logic        vs_pol;
    } mode_params_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EOF,
        ST_RESET_GEN,
        ST_MUTE,
        ST_ACK
    } vmc_state_t;

    // Unknown codes fall back to the power-on mode so the generator never sees garbage.
    function automatic mode_params_t mode_params(input logic [1:0] mode);
        mode_params_t p;
        case (mode)
            MODE_800x600: p = '{h_total: 12'd1056, h_sync: 12'd128, h_bporch: 12'd88,
                                h_res: 12'd800, v_total: 12'd628, v_sync: 12'd4,
                                v_bporch: 12'd23, v_res: 12'd600, hs_pol: 1'b1, vs_pol: 1'b1};
            MODE_1024x768: p = '{h_total: 12'd1344, h_sync: 12'd136, h_bporch: 12'd160,
                                 h_res: 12'd1024, v_total: 12'd806, v_sync: 12'd6,
                                 v_bporch: 12'd29, v_res: 12'd768, hs_pol: 1'b0, vs_pol: 1'b0};
            default: p = '{h_total: 12'd1650, h_sync: 12'd40, h_bporch: 12'd220,
                           h_res: 12'd1280, v_total: 12'd750, v_sync: 12'd5,
                           v_bporch: 12'd20, v_res: 12'd720, hs_pol: 1'b1, vs_pol: 1'b1};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/video_eof_detect.sv
// rtl/video_eof_detect.sv - registered vsync and polarity-aware end-of-frame pulse
module video_eof_detect (
    input  logic pix_clk,
    input  logic reset_n,
    input  logic vs,
    input  logic vs_pol,
    input  logic clear,
    output logic eof
);

    logic vs_cur;
    logic vs_prev;

    // Clearing forces the history to the inactive level so no stale edge survives a mode change.
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_cur  <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_cur  <= vs;
            vs_prev <= clear ? ~vs_pol : vs_cur;
        end
    end

    assign eof = (vs_prev == vs_pol) && (vs_cur != vs_pol);

endmodule

// File: rtl/video_mode_controller.sv
// rtl/video_mode_controller.sv - frame-aligned video mode switch sequencer and frame counter
module video_mode_controller
    import vdp_video_pkg::*;
#(
    parameter int MUTE_FRAMES = 2,
    parameter int RST_CYCLES  = 16,
    parameter int VS_TIMEOUT  = 2097152,
    parameter int PAT_SHIFT   = 8
) (
    input  logic        pix_clk,
    input  logic        reset_n,
    input  logic        I_vs,
    input  logic        I_mode_req,
    input  logic [1:0]  I_mode_sel,
    output logic        O_mode_ack,
    output logic        O_mode_err,
    output logic        O_busy,
    output logic [1:0]  O_cur_mode,
    output logic [11:0] O_h_total,
    output logic [11:0] O_h_sync,
    output logic [11:0] O_h_bporch,
    output logic [11:0] O_h_res,
    output logic [11:0] O_v_total,
    output logic [11:0] O_v_sync,
    output logic [11:0] O_v_bporch,
    output logic [11:0] O_v_res,
    output logic        O_hs_pol,
    output logic        O_vs_pol,
    output logic        O_timing_rst_n,
    output logic        O_mute,
    output logic [2:0]  O_pattern
);

    localparam int               TMO_W     = $clog2(VS_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(VS_TIMEOUT - 1);
    localparam logic [7:0]       RST_LAST  = 8'(RST_CYCLES - 1);
    localparam logic [3:0]       MUTE_LAST = 4'(MUTE_FRAMES - 1);

    vmc_state_t       state;
    mode_params_t     params;
    logic [1:0]       cur_mode;
    logic [1:0]       req_mode;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       rst_cnt;
    logic [3:0]       mute_cnt;
    logic [9:0]       frame_cnt;
    logic             ack;
    logic             err;
    logic             busy;
    logic             timing_rst_n;
    logic             mute;
    logic             eof;

    video_eof_detect u_eof (
        .pix_clk (pix_clk),
        .reset_n (reset_n),
        .vs      (I_vs),
        .vs_pol  (params.vs_pol),
        .clear   (state == ST_RESET_GEN),
        .eof     (eof)
    );

    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            params       <= mode_params(MODE_1280x720);
            cur_mode     <= MODE_1280x720;
            req_mode     <= MODE_1280x720;
            tmo_cnt      <= '0;
            rst_cnt      <= '0;
            mute_cnt     <= '0;
            frame_cnt    <= '0;
            ack          <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            timing_rst_n <= 1'b1;
            mute         <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            // The generator is frozen during RESET_GEN, so any vsync edge seen there is not a frame.
            if (eof && state != ST_RESET_GEN) begin
                frame_cnt <= frame_cnt + 10'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (I_mode_req) begin
                        req_mode <= I_mode_sel;
                        busy     <= 1'b1;
                        if (I_mode_sel == MODE_INVALID) begin
                            state <= ST_ACK;
                            ack   <= 1'b1;
                            err   <= 1'b1;
                        end else if (I_mode_sel == cur_mode) begin
                            state <= ST_ACK;
                            ack   <= 1'b1;
                        end else begin
                            state   <= ST_WAIT_EOF;
                            tmo_cnt <= '0;
                        end
                    end
                end
                ST_WAIT_EOF: begin
                    if (eof || tmo_cnt == TMO_LAST) begin
                        state        <= ST_RESET_GEN;
                        params       <= mode_params(req_mode);
                        cur_mode     <= req_mode;
                        timing_rst_n <= 1'b0;
                        mute         <= 1'b1;
                        rst_cnt      <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESET_GEN: begin
                    if (rst_cnt == RST_LAST) begin
                        state        <= ST_MUTE;
                        timing_rst_n <= 1'b1;
                        frame_cnt    <= '0;
                        mute_cnt     <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end
                ST_MUTE: begin
                    if (eof) begin
                        if (mute_cnt == MUTE_LAST) begin
                            state <= ST_ACK;
                            ack   <= 1'b1;
                        end else begin
                            mute_cnt <= mute_cnt + 4'd1;
                        end
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    mute  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign O_mode_ack     = ack;
    assign O_mode_err     = err;
    assign O_busy         = busy;
    assign O_cur_mode     = cur_mode;
    assign O_h_total      = params.h_total;
    assign O_h_sync       = params.h_sync;
    assign O_h_bporch     = params.h_bporch;
    assign O_h_res        = params.h_res;
    assign O_v_total      = params.v_total;
    assign O_v_sync       = params.v_sync;
    assign O_v_bporch     = params.v_bporch;
    assign O_v_res        = params.v_res;
    assign O_hs_pol       = params.hs_pol;
    assign O_vs_pol       = params.vs_pol;
    assign O_timing_rst_n = timing_rst_n;
    assign O_mute         = mute;
    assign O_pattern      = {1'b0, frame_cnt[PAT_SHIFT+1:PAT_SHIFT]};

endmodule

// File: tb/tb_video_mode_controller.sv
// tb/tb_video_mode_controller.sv - scoreboard bench for video_mode_controller with a small vsync model
module tb_video_mode_controller;

    localparam int FRAME  = 40;
    localparam int VS_LEN = 4;

    logic        pix_clk = 1'b0;
    logic        reset_n;
    logic        I_vs;
    logic        I_mode_req;
    logic [1:0]  I_mode_sel;
    logic        O_mode_ack, O_mode_err, O_busy;
    logic [1:0]  O_cur_mode;
    logic [11:0] O_h_total, O_h_sync, O_h_bporch, O_h_res;
    logic [11:0] O_v_total, O_v_sync, O_v_bporch, O_v_res;
    logic        O_hs_pol, O_vs_pol, O_timing_rst_n, O_mute;
    logic [2:0]  O_pattern;

    typedef struct {
        logic        err;
        logic [1:0]  mode;
        logic [97:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acks = 0;
    int   vcnt = 0;
    int   ends = 0;
    int   tick = 0;
    int   last_end_tick = 0;
    bit   stall = 1'b0;
    bit   prev_act = 1'b0;
    bit   gen_act;

    always #5 pix_clk = ~pix_clk;

    video_mode_controller #(
        .MUTE_FRAMES (2),
        .RST_CYCLES  (16),
        .VS_TIMEOUT  (64),
        .PAT_SHIFT   (8)
    ) dut (
        .pix_clk        (pix_clk),
        .reset_n        (reset_n),
        .I_vs           (I_vs),
        .I_mode_req     (I_mode_req),
        .I_mode_sel     (I_mode_sel),
        .O_mode_ack     (O_mode_ack),
        .O_mode_err     (O_mode_err),
        .O_busy         (O_busy),
        .O_cur_mode     (O_cur_mode),
        .O_h_total      (O_h_total),
        .O_h_sync       (O_h_sync),
        .O_h_bporch     (O_h_bporch),
        .O_h_res        (O_h_res),
        .O_v_total      (O_v_total),
        .O_v_sync       (O_v_sync),
        .O_v_bporch     (O_v_bporch),
        .O_v_res        (O_v_res),
        .O_hs_pol       (O_hs_pol),
        .O_vs_pol       (O_vs_pol),
        .O_timing_rst_n (O_timing_rst_n),
        .O_mute         (O_mute),
        .O_pattern      (O_pattern)
    );

    function automatic logic [97:0] exp_p(input int m);
        case (m)
            0: return {12'd1056, 12'd128, 12'd88, 12'd800, 12'd628, 12'd4, 12'd23, 12'd600, 2'b11};
            1: return {12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 2'b00};
            default: return {12'd1650, 12'd40, 12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 2'b11};
        endcase
    endfunction

    function automatic logic [97:0] params_now();
        return {O_h_total, O_h_sync, O_h_bporch, O_h_res, O_v_total, O_v_sync,
                O_v_bporch, O_v_res, O_hs_pol, O_vs_pol};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_wait();
        @(posedge pix_clk);
        #1;
    endtask

    // Vsync model: held at frame start while the generator is in reset, follows O_vs_pol.
    initial begin
        I_vs = 1'b0;
        forever begin
            @(negedge pix_clk);
            tick++;
            if (!O_timing_rst_n) begin
                vcnt = 0;
                ends = 0;
            end else begin
                vcnt = (vcnt == FRAME - 1) ? 0 : vcnt + 1;
            end
            I_vs = stall ? 1'b0 : ((vcnt < VS_LEN) ? O_vs_pol : ~O_vs_pol);
            gen_act = (I_vs == O_vs_pol);
            if (prev_act && !gen_act && O_timing_rst_n) begin
                ends++;
                last_end_tick = tick;
            end
            prev_act = gen_act;
        end
    end

    initial begin
        exp_t e;
        forever begin
            tick_wait();
            if (O_mode_ack) begin
                n_acks++;
                if (sb.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_err", O_mode_err, e.err);
                    check("ack_mode", O_cur_mode, e.mode);
                    check("ack_params", params_now(), e.p);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_vcnt(input int v);
        int n = 0;
        while (vcnt != v && n < 200) begin
            tick_wait();
            n++;
        end
        check("vcnt_reached", vcnt, v);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!O_mode_ack && n < 400) begin
            tick_wait();
            n++;
        end
        check("ack_seen", O_mode_ack, 1);
    endtask

    task automatic switch_mode(input int sel, input bit via_eof);
        int n;
        logic [97:0] ep;
        ep = exp_p(sel);
        sb.push_back(exp_t'{1'b0, 2'(sel), ep});
        I_mode_req = 1'b1;
        I_mode_sel = 2'(sel);
        tick_wait();
        check("busy_after_accept", O_busy, 1);
        I_mode_req = 1'b0;
        n = 0;
        while (O_timing_rst_n && n < 200) begin
            tick_wait();
            n++;
        end
        check("gen_reset_asserted", O_timing_rst_n, 0);
        if (via_eof) check("reset_after_vs_end", tick - last_end_tick, 1);
        else         check("timeout_forced_switch", n, 64);
        stall = 1'b0;
        check("params_at_reset", params_now(), ep);
        check("mode_at_reset", O_cur_mode, sel);
        check("mute_during_reset", O_mute, 1);
        n = 0;
        while (!O_timing_rst_n && n < 100) begin
            tick_wait();
            n++;
        end
        check("reset_len", n, 16);
        wait_ack();
        check("eofs_before_ack", ends, 2);
        tick_wait();
        check("mute_after_ack", O_mute, 0);
        check("busy_after_ack", O_busy, 0);
    endtask

    task automatic quick_req(input int sel, input bit err);
        int n = 0;
        bit bad = 1'b0;
        sb.push_back(exp_t'{err, 2'd2, exp_p(2)});
        I_mode_req = 1'b1;
        I_mode_sel = 2'(sel);
        do begin
            tick_wait();
            n++;
            if (!O_timing_rst_n || O_mute) bad = 1'b1;
        end while (!O_mode_ack && n < 2);
        check("quick_ack_in_2", O_mode_ack, 1);
        I_mode_req = 1'b0;
        tick_wait();
        check("quick_busy_clear", O_busy, 0);
        check("quick_no_reset_no_mute", bad, 0);
    endtask

    initial begin
        int last;
        int n;
        reset_n    = 1'b1;
        I_mode_req = 1'b0;
        I_mode_sel = 2'd0;
        #2;
        reset_n = 1'b0;
        repeat (3) tick_wait();
        check("rst_params", params_now(), exp_p(2));
        check("rst_mode", O_cur_mode, 2);
        check("rst_timing_rst_n", O_timing_rst_n, 1);
        check("rst_mute", O_mute, 0);
        check("rst_busy", O_busy, 0);
        check("rst_ack_err", {O_mode_ack, O_mode_err}, 0);
        check("rst_pattern", O_pattern, 0);
        reset_n = 1'b1;

        repeat (3 * FRAME) tick_wait();
        check("idle_params", params_now(), exp_p(2));
        check("idle_pattern", O_pattern, 0);
        check("idle_mute", O_mute, 0);
        check("idle_no_ack", n_acks, 0);

        wait_vcnt(20);
        switch_mode(0, 1'b1);
        switch_mode(1, 1'b1);
        check("mode1_vs_pol", {O_hs_pol, O_vs_pol}, 0);
        switch_mode(2, 1'b1);

        quick_req(3, 1'b1);
        quick_req(2, 1'b0);

        wait_vcnt(20);
        stall = 1'b1;
        switch_mode(0, 1'b0);

        while (ends < 767) begin
            last = ends;
            n = 0;
            while (ends == last && n < 100) begin
                tick_wait();
                n++;
            end
            if (ends == last) begin
                check("frame_end_seen", 0, 1);
                break;
            end
            tick_wait();
            check("pattern", O_pattern, (ends >> 8) & 3);
        end

        I_mode_req = 1'b1;
        I_mode_sel = 2'd1;
        tick_wait();
        I_mode_req = 1'b0;
        n = 0;
        while (O_timing_rst_n && n < 200) begin
            tick_wait();
            n++;
        end
        n = 0;
        while (!O_timing_rst_n && n < 100) begin
            tick_wait();
            n++;
        end
        repeat (3) tick_wait();
        check("abort_in_mute", {O_mute, O_busy, O_timing_rst_n}, 3'b111);
        reset_n = 1'b0;
        #1;
        check("abort_params", params_now(), exp_p(2));
        check("abort_mode", O_cur_mode, 2);
        check("abort_flags", {O_busy, O_mute, O_timing_rst_n, O_mode_ack}, 4'b0010);
        check("abort_pattern", O_pattern, 0);
        repeat (3) tick_wait();
        reset_n = 1'b1;
        repeat (5) tick_wait();
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_mode_controller.md
Name: video_mode_controller

Overview:
- Sequences and configures the video timing/pattern datapath: owns the timing parameter set (h/v total, sync, back porch, resolution, polarities) that feeds the plane mixer's timing generator, plus the test-pattern select.
- Performs glitch-free mode switches at frame boundaries: waits for end of vsync, holds the generator in reset, applies new parameters atomically, mutes output for a number of frames, then acknowledges.
- Replaces the free-running frame counter in the top level. Sits between the top level / control logic and the plane mixer, in the pix_clk domain.

Parameters:
- MUTE_FRAMES, 2, frames with O_mute high after a switch (1..15).
- RST_CYCLES, 16, pix_clk cycles O_timing_rst_n is held low (2..255).
- VS_TIMEOUT, 2097152, max cycles waiting for end of vsync before forcing the switch.
- PAT_SHIFT, 8, log2 of frames per test pattern step.

Ports:
- pix_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- I_vs  in  1  vsync from the timing generator, in the current O_vs_pol polarity
- I_mode_req  in  1  mode change request, level
- I_mode_sel  in  2  requested mode: 0=800x600, 1=1024x768, 2=1280x720, 3=invalid
- O_mode_ack  out  1  one-cycle pulse: request completed
- O_mode_err  out  1  one-cycle pulse, coincident with ack: invalid mode, no change
- O_busy  out  1  high from accept until ack
- O_cur_mode  out  2  currently applied mode
- O_h_total, O_h_sync, O_h_bporch, O_h_res, O_v_total, O_v_sync, O_v_bporch, O_v_res  out  12 each  timing parameters
- O_hs_pol, O_vs_pol  out  1 each  sync polarities, 1=positive
- O_timing_rst_n  out  1  active-low reset to the timing generator
- O_mute  out  1  force-black request to the mixer
- O_pattern  out  3  test pattern select

Behaviour:
- Mode table (total, sync, bporch, res for h then v; hs/vs polarity):
  - Mode 0: 1056, 128, 88, 800; 628, 4, 23, 600; pol 1/1.
  - Mode 1: 1344, 136, 160, 1024; 806, 6, 29, 768; pol 0/0.
  - Mode 2: 1650, 40, 220, 1280; 750, 5, 20, 720; pol 1/1.
- Reset values:
  - O_cur_mode=2 with mode 2 parameters.
  - O_timing_rst_n=1, O_mute=0, O_busy=0, O_mode_ack=0, O_mode_err=0, O_pattern=0.
  - Frame counter=0, state=IDLE.
- End-of-frame event (eof): I_vs registered once. eof = previous sample active and current sample inactive, with "active" per current O_vs_pol.
- Frame counter: 10 bits, +1 on each eof, wraps 1023->0.
  - O_pattern = {1'b0, cnt[PAT_SHIFT+1:PAT_SHIFT]}.
  - Counter cleared when the generator is released from reset.
- FSM states:
  - IDLE: I_mode_req sampled here only; the selected mode is latched on accept.
    - sel=3 -> ACK with err.
    - sel==O_cur_mode -> ACK, no switch.
    - Otherwise -> WAIT_EOF. O_busy rises the cycle after accept.
  - WAIT_EOF: on eof, or when the timeout counter reaches VS_TIMEOUT-1 -> RESET_GEN.
  - RESET_GEN: O_timing_rst_n=0 and O_mute=1 for RST_CYCLES cycles.
    - All parameter outputs and O_cur_mode update together on the first cycle of this state.
    - On exit, release the generator, clear the frame counter and the eof history -> MUTE.
  - MUTE: O_mute=1. Count MUTE_FRAMES eof events (evaluated with the new polarity) -> ACK.
  - ACK: O_mode_ack=1 (O_mode_err=1 if invalid) for one cycle; O_busy=0 and O_mute=0 next cycle -> IDLE.
- Handshake:
  - The requester must drop I_mode_req within one cycle after ack.
  - A req still high in the IDLE cycle after ack is treated as a new request.
  - Req changes while busy are ignored.
  - I_mode_sel is sampled only at accept.
- Simultaneous events:
  - eof in the same cycle as accept is not counted; WAIT_EOF waits for the next eof.
  - The frame counter still increments on eof in every state except RESET_GEN.
- Reset mid-operation: all state returns to reset values immediately, including mode 2 parameters.
- No combinational path from inputs to outputs; all outputs registered.

Decomposition:
- Package vdp_video_pkg:
  - mode encoding constants MODE_800x600, MODE_1024x768, MODE_1280x720.
  - mode-parameter struct (8x12-bit plus 2 polarities) and the constant table function mode_params(mode).
  - FSM state typedef.
- One sub-module, video_eof_detect: registered vsync, polarity-aware end-of-frame pulse; reusable by the top level.

Test Plan:
- Reset, then idle 3 frames of a model generator (mode 2) -> parameters 1650/40/220/1280/750/5/20/720, O_pattern=0, no ack, O_mute=0.
- Request sel=0 mid-frame -> O_busy next cycle; O_timing_rst_n low exactly 16 cycles starting after the vs falling edge; parameters switch to 1056/128/88/800/628/4/23/600; ack after 2 further eofs; O_mute low after ack.
- Request sel=1 from mode 0 -> polarity 0/0 applied; MUTE counts rising-edge eofs of the negative-polarity vsync; O_cur_mode=1 after ack.
- Request sel=3, then sel=2 while in mode 2 -> each gives ack within 2 cycles, err=1 only for sel=3; no reset pulse, no mute.
- Stalled I_vs (held 0) with VS_TIMEOUT=64 -> switch forced 64 cycles after WAIT_EOF entry; sequence completes once vsync resumes.
- 768 eofs in one mode -> O_pattern steps 0,1,2 at frames 256 and 512; assert reset_n low in MUTE -> immediate mode 2 defaults, busy=0.
